// File: rtl/addr_map_rule_pkg.sv
// addr_map_rule_pkg
//   Address-map rule type and the external crossbar rule table. Each rule
//   maps the half-open byte range [start_addr, end_addr) to slave port idx.
//   Rule 0 is the slow memory and rule 1 is the serial-link external slave.
//   No ports.
package addr_map_rule_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam logic [31:0] EXT_SLAVE_START_ADDRESS   = 32'hF000_0000;
  localparam logic [31:0] SLOW_MEMORY_START_ADDRESS = 32'hF001_0000;
  localparam logic [31:0] SLOW_MEMORY_END_ADDRESS   = 32'hF002_0000;
  localparam logic [31:0] SL_EXT_START_ADDRESS      = 32'hF010_0000;
  localparam logic [31:0] SL_EXT_END_ADDRESS        = 32'hF011_0000;

  // Concatenation is MSB first, so element [0] is the slow memory rule.
  localparam addr_map_rule_t [1:0] EXT_XBAR_ADDR_RULES = {
    addr_map_rule_t'{idx: 32'd1, start_addr: SL_EXT_START_ADDRESS,
                     end_addr: SL_EXT_END_ADDRESS},
    addr_map_rule_t'{idx: 32'd0, start_addr: SLOW_MEMORY_START_ADDRESS,
                     end_addr: SLOW_MEMORY_END_ADDRESS}
  };

endpackage

// File: rtl/obi_ext_xbar_demux_pkg.sv
// obi_ext_xbar_demux_pkg
//   Shared types for the external OBI demultiplexer: target index (one code
//   per slave plus the internal error responder), the error-target code and
//   the outstanding-transaction counter. Sized for the external crossbar
//   rule table (2 slaves, 4 outstanding). No ports.
package obi_ext_xbar_demux_pkg;

  localparam int unsigned EXT_NSLAVE          = 2;
  localparam int unsigned EXT_MAX_OUTSTANDING = 4;

  localparam int unsigned TGT_W = $clog2(EXT_NSLAVE + 1);
  typedef logic [TGT_W-1:0] tgt_idx_t;

  // Unmapped accesses are steered to this code, one past the last slave.
  localparam tgt_idx_t ERR_TGT = tgt_idx_t'(EXT_NSLAVE);

  localparam int unsigned CNT_W = $clog2(EXT_MAX_OUTSTANDING + 1);
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/obi_ext_addr_decode.sv
// obi_ext_addr_decode
//   Combinational address decoder. A rule hits when
//   start_addr <= addr < end_addr; when several hit, the lowest rule index
//   wins. No hit yields target = ERR_TGT and hit = 0.
//   Ports:
//     addr    in  32         byte address
//     target  out tgt_idx_t  selected slave index, or ERR_TGT
//     hit     out 1          some rule matched
module obi_ext_addr_decode
  import addr_map_rule_pkg::*;
  import obi_ext_xbar_demux_pkg::*;
#(
  parameter int unsigned                     NSLAVE     = EXT_NSLAVE,
  parameter addr_map_rule_t [NSLAVE-1:0]     ADDR_RULES = EXT_XBAR_ADDR_RULES
) (
  input  logic [31:0] addr,
  output tgt_idx_t    target,
  output logic        hit
);

  logic [NSLAVE-1:0] match;

  generate
    for (genvar gi = 0; gi < NSLAVE; gi++) begin : g_match
      assign match[gi] = (addr >= ADDR_RULES[gi].start_addr) &&
                         (addr <  ADDR_RULES[gi].end_addr);
    end
  endgenerate

  // Walk from the highest index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    target = ERR_TGT;
    hit    = 1'b0;
    for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
      if (match[i]) begin
        target = tgt_idx_t'(ADDR_RULES[i].idx);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_ext_xbar_demux.sv
// obi_ext_xbar_demux
//   Single-master OBI demultiplexer in front of the external slaves. Each
//   request is decoded against the rule table and forwarded to one slave;
//   unmapped requests are answered by an internal error responder one cycle
//   after grant. Responses come back in issue order because a new target is
//   only accepted once nothing is outstanding.
//   Optional: define OBI_EXT_XBAR_DEMUX_ERR_CAPTURE_EN to add err_addr_o and
//   err_cnt_o (last unmapped address, saturating unmapped-access count).
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     m_req_i/m_gnt_o              master request / combinational grant
//     m_addr_i/m_we_i/m_be_i/m_wdata_i  master request fields
//     m_rvalid_o/m_rdata_o         master response (rdata 0 when not valid)
//     s_req_o/s_gnt_i              per-slave request / grant
//     s_addr_o/s_we_o/s_be_o/s_wdata_o  broadcast request fields
//     s_rvalid_i/s_rdata_i         per-slave response
//     err_addr_o/err_cnt_o         optional unmapped-access capture
module obi_ext_xbar_demux
  import addr_map_rule_pkg::*;
  import obi_ext_xbar_demux_pkg::*;
#(
  parameter int unsigned                 NSLAVE          = EXT_NSLAVE,
  parameter int unsigned                 MAX_OUTSTANDING = EXT_MAX_OUTSTANDING,
  parameter addr_map_rule_t [NSLAVE-1:0] ADDR_RULES      = EXT_XBAR_ADDR_RULES,
  parameter logic [31:0]                 ERR_RDATA       = 32'hBADACCE5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m_req_i,
  output logic                     m_gnt_o,
  input  logic [31:0]              m_addr_i,
  input  logic                     m_we_i,
  input  logic [3:0]               m_be_i,
  input  logic [31:0]              m_wdata_i,
  output logic                     m_rvalid_o,
  output logic [31:0]              m_rdata_o,
  output logic [NSLAVE-1:0]        s_req_o,
  input  logic [NSLAVE-1:0]        s_gnt_i,
  output logic [NSLAVE-1:0][31:0]  s_addr_o,
  output logic [NSLAVE-1:0]        s_we_o,
  output logic [NSLAVE-1:0][3:0]   s_be_o,
  output logic [NSLAVE-1:0][31:0]  s_wdata_o,
  input  logic [NSLAVE-1:0]        s_rvalid_i,
  input  logic [NSLAVE-1:0][31:0]  s_rdata_i
`ifdef OBI_EXT_XBAR_DEMUX_ERR_CAPTURE_EN
  ,
  output logic [31:0]              err_addr_o,
  output logic [15:0]              err_cnt_o
`endif
);

  tgt_idx_t          target;
  logic              hit;
  logic              gate_open, sel_gnt, handshake, err_grant;
  logic              sel_rvalid, slave_rvalid;
  logic [31:0]       sel_rdata;
  cnt_t              cnt_reg, cnt_next;
  tgt_idx_t          last_tgt_reg;
  logic              err_pend_reg, err_we_reg;
  logic [NSLAVE-1:0] rvalid_expected;

  obi_ext_addr_decode #(
    .NSLAVE     (NSLAVE),
    .ADDR_RULES (ADDR_RULES)
  ) u_decode (
    .addr   (m_addr_i),
    .target (target),
    .hit    (hit)
  );

  // Switching target is only safe with nothing in flight; that alone keeps
  // responses in issue order. Held closed during reset so grants stay 0.
  assign gate_open = !rst_i &&
                     (cnt_reg < cnt_t'(MAX_OUTSTANDING)) &&
                     ((cnt_reg == '0) || (target == last_tgt_reg));

  always_comb begin
    sel_gnt = 1'b0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (target == tgt_idx_t'(i)) sel_gnt = s_gnt_i[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NSLAVE; gi++) begin : g_fwd
      assign s_req_o[gi]   = gate_open && m_req_i && (target == tgt_idx_t'(gi));
      assign s_addr_o[gi]  = m_addr_i;
      assign s_we_o[gi]    = m_we_i;
      assign s_be_o[gi]    = m_be_i;
      assign s_wdata_o[gi] = m_wdata_i;
      assign rvalid_expected[gi] = (cnt_reg != '0) && (last_tgt_reg == tgt_idx_t'(gi));
    end
  endgenerate

  // The error responder grants whatever it is asked for immediately.
  assign m_gnt_o   = gate_open && (hit ? sel_gnt : m_req_i);
  assign handshake = m_req_i && m_gnt_o;
  assign err_grant = handshake && !hit;

  // Only the slave that owns the outstanding transactions may respond.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (last_tgt_reg == tgt_idx_t'(i)) begin
        sel_rvalid = s_rvalid_i[i];
        sel_rdata  = s_rdata_i[i];
      end
    end
  end

  assign slave_rvalid = sel_rvalid && (cnt_reg != '0);
  assign m_rvalid_o   = err_pend_reg || slave_rvalid;

  always_comb begin
    m_rdata_o = '0;
    if (err_pend_reg) begin
      m_rdata_o = err_we_reg ? 32'h0 : ERR_RDATA;
    end else if (slave_rvalid) begin
      m_rdata_o = sel_rdata;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({handshake, m_rvalid_o})
      2'b10:   cnt_next = cnt_reg + cnt_t'(1);
      2'b01:   cnt_next = cnt_reg - cnt_t'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg      <= '0;
      last_tgt_reg <= ERR_TGT;
      err_pend_reg <= 1'b0;
      err_we_reg   <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      err_pend_reg <= err_grant;
      if (handshake) last_tgt_reg <= target;
      if (err_grant) err_we_reg   <= m_we_i;
    end
  end

`ifdef OBI_EXT_XBAR_DEMUX_ERR_CAPTURE_EN
  logic [31:0] err_addr_reg;
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_reg <= '0;
      err_cnt_reg  <= '0;
    end else if (err_grant) begin
      err_addr_reg <= m_addr_i;
      if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_addr_o = err_addr_reg;
  assign err_cnt_o  = err_cnt_reg;
`endif

  // Slave protocol violations: these responses are dropped by the mux above.
  a_rvalid_wrong_slave: assert property (@(posedge clk_i) disable iff (rst_i)
    (cnt_reg != '0) |-> ((s_rvalid_i & ~rvalid_expected) == '0));
  a_rvalid_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (cnt_reg == '0) |-> (s_rvalid_i == '0));

endmodule

// File: tb/tb_obi_ext_xbar_demux.sv
// tb_obi_ext_xbar_demux
//   Directed bench for obi_ext_xbar_demux. Expected read data is pushed into
//   a scoreboard queue when each request is issued; a monitor pops and
//   compares on every m_rvalid_o. Slave models return addr ^ KEY for reads
//   and 0 for writes, after a per-slave latency that can be held off.
module tb_obi_ext_xbar_demux;
  import addr_map_rule_pkg::*;

  localparam int          NS  = 2;
  localparam logic [31:0] KEY = 32'hE2355668;  // SLOW+0x10 ^ KEY = 12345678

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 m_req_i, m_gnt_o, m_we_i, m_rvalid_o;
  logic [31:0]          m_addr_i, m_wdata_i, m_rdata_o;
  logic [3:0]           m_be_i;
  logic [NS-1:0]        s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
  logic [NS-1:0][31:0]  s_addr_o, s_wdata_o, s_rdata_i;
  logic [NS-1:0][3:0]   s_be_o;
`ifdef OBI_EXT_XBAR_DEMUX_ERR_CAPTURE_EN
  logic [31:0]          err_addr_o;
  logic [15:0]          err_cnt_o;
`endif

  obi_ext_xbar_demux dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_req_i    (m_req_i),
    .m_gnt_o    (m_gnt_o),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_gnt_i    (s_gnt_i),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i)
`ifdef OBI_EXT_XBAR_DEMUX_ERR_CAPTURE_EN
    ,
    .err_addr_o (err_addr_o),
    .err_cnt_o  (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rsp = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  int          rv_cycles[$];
  logic [NS-1:0] gnt_en;
  logic [NS-1:0] hold;
  int          lat[NS];

  always @(posedge clk_i) cyc <= cyc + 1;

  assign s_gnt_i = gnt_en;

  typedef struct {
    logic [31:0] data;
    int          rdy;
  } sresp_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Slave models: accept on s_req&s_gnt, respond in order after lat cycles.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slv
      sresp_t      q[$];
      logic        rv = 1'b0;
      logic [31:0] rd = '0;
      assign s_rvalid_i[gi] = rv;
      assign s_rdata_i[gi]  = rd;
      initial begin
        logic        hs, popped, w, r;
        logic [31:0] a;
        forever begin
          @(posedge clk_i);
          hs     = s_req_o[gi] & s_gnt_i[gi];
          popped = rv;
          a      = s_addr_o[gi];
          w      = s_we_o[gi];
          r      = rst_i;
          #1;
          if (r) begin
            q.delete();
          end else begin
            if (popped && q.size() > 0) void'(q.pop_front());
            if (hs) q.push_back('{data: (w ? 32'h0 : (a ^ KEY)), rdy: cyc + lat[gi]});
          end
          if (!r && q.size() > 0 && q[0].rdy <= cyc && !hold[gi]) begin
            rv = 1'b1;
            rd = q[0].data;
          end else begin
            rv = 1'b0;
            rd = '0;
          end
        end
      end
    end
  endgenerate

  // Response monitor / scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && m_rvalid_o) begin
      rv_cycles.push_back(cyc);
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rdata %h, required no response", m_rdata_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("rsp %0d @cyc %0d: rdata=%h expected=%h", n_rsp, cyc, m_rdata_o, e);
        check("rdata", m_rdata_o, e);
      end
    end
  end

  task automatic start_req(input logic [31:0] a, input logic we, input logic [31:0] exp);
    m_req_i   = 1'b1;
    m_addr_i  = a;
    m_we_i    = we;
    m_be_i    = 4'hF;
    m_wdata_i = a ^ 32'h5555_0000;
    exp_q.push_back(exp);
  endtask

  // Hold the request until granted; checks which slave saw it at grant.
  task automatic wait_gnt(input string nm, input logic [NS-1:0] exp_sreq, output int gc);
    int   n;
    logic g;
    n  = 0;
    g  = 1'b0;
    gc = -1;
    do begin
      @(negedge clk_i);
      g = m_gnt_o;
      if (g) begin
        gc = cyc;
        check({nm, "_sreq"}, 32'(s_req_o), 32'(exp_sreq));
      end
      @(posedge clk_i);
      #1;
      n++;
    end while (!g && n < 50);
    if (!g) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_gnt_timeout: got no grant in 50 cycles, required a grant", nm);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    m_req_i = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_rv_first(input string nm, input int req);
    if (rv_cycles.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no rvalid, required rvalid at cycle %0d", nm, req);
    end else begin
      check(nm, 32'(rv_cycles[0]), 32'(req));
    end
  endtask

  task automatic blocked_cycles(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      check({nm, "_sreq_blocked"}, 32'(s_req_o), 32'd0);
      check({nm, "_gnt_blocked"}, 32'(m_gnt_o), 32'd0);
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[6];
    int gc, sc;

    rst_i = 1'b1;
    gnt_en = 2'b11;
    hold = 2'b00;
    lat[0] = 3;
    lat[1] = 2;
    m_req_i = 1'b1;
    m_addr_i = SLOW_MEMORY_START_ADDRESS;
    m_we_i = 1'b0;
    m_be_i = 4'hF;
    m_wdata_i = '0;

    // Reset state, with a live request on the master side.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_gnt", 32'(m_gnt_o), 32'd0);
    check("rst_rvalid", 32'(m_rvalid_o), 32'd0);
    check("rst_rdata", m_rdata_o, 32'd0);
    check("rst_sreq", 32'(s_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_cnt", 32'(dut.cnt_reg), 32'd0);

    // 1: mapped read to slave 0.
    start_req(SLOW_MEMORY_START_ADDRESS + 32'h10, 1'b0, 32'h12345678);
    wait_gnt("t1", 2'b01, gc);
    drain("t1");
    check("t1_cnt", 32'(dut.cnt_reg), 32'd0);

    // 2: unmapped read, same-cycle grant, response next cycle.
    rv_cycles.delete();
    sc = cyc;
    start_req(EXT_SLAVE_START_ADDRESS + 32'h8000, 1'b0, 32'hBADACCE5);
    wait_gnt("t2", 2'b00, gc);
    check("t2_gnt_cycle", 32'(gc), 32'(sc));
    drain("t2");
    check_rv_first("t2_rvalid_cycle", gc + 1);

    // 3: six back-to-back reads to slave 0 with responses held.
    lat[0] = 1;
    hold[0] = 1'b1;
    rv_cycles.delete();
    for (int k = 0; k < 4; k++) begin
      start_req(SLOW_MEMORY_START_ADDRESS + 32'(4 * k), 1'b0,
                (SLOW_MEMORY_START_ADDRESS + 32'(4 * k)) ^ KEY);
      wait_gnt("t3", 2'b01, g[k]);
    end
    check("t3_b2b", 32'(g[3]), 32'(g[0] + 3));
    start_req(SLOW_MEMORY_START_ADDRESS + 32'h10, 1'b0, 32'h12345678);
    blocked_cycles("t3", 3);
    hold[0] = 1'b0;
    wait_gnt("t3_5th", 2'b01, g[4]);
    start_req(SLOW_MEMORY_START_ADDRESS + 32'h14, 1'b0,
              (SLOW_MEMORY_START_ADDRESS + 32'h14) ^ KEY);
    wait_gnt("t3_6th", 2'b01, g[5]);
    check_rv_first("t3_5th_after_rvalid", g[4] - 1);
    drain("t3");
    check("t3_cnt", 32'(dut.cnt_reg), 32'd0);

    // 4: target switch waits for slave 0 to finish.
    hold[0] = 1'b1;
    rv_cycles.delete();
    start_req(SLOW_MEMORY_START_ADDRESS + 32'h20, 1'b0,
              (SLOW_MEMORY_START_ADDRESS + 32'h20) ^ KEY);
    wait_gnt("t4_s0", 2'b01, gc);
    start_req(SL_EXT_START_ADDRESS, 1'b0, SL_EXT_START_ADDRESS ^ KEY);
    blocked_cycles("t4", 3);
    hold[0] = 1'b0;
    wait_gnt("t4_s1", 2'b10, gc);
    check_rv_first("t4_s1_after_rvalid", gc - 1);
    drain("t4");

    // 5: exclusive end address goes to ERR, END-4 to slave 0.
    start_req(SLOW_MEMORY_END_ADDRESS, 1'b0, 32'hBADACCE5);
    wait_gnt("t5_end", 2'b00, gc);
    start_req(SLOW_MEMORY_END_ADDRESS - 32'd4, 1'b0, (SLOW_MEMORY_END_ADDRESS - 32'd4) ^ KEY);
    wait_gnt("t5_endm4", 2'b01, gc);
    drain("t5");

    // 6: three unmapped writes, then reset with two reads outstanding.
    start_req(32'hF000_8000, 1'b1, 32'h0);
    wait_gnt("t6_w0", 2'b00, gc);
    start_req(32'hF000_9000, 1'b1, 32'h0);
    wait_gnt("t6_w1", 2'b00, gc);
    start_req(32'hF003_0000, 1'b1, 32'h0);
    wait_gnt("t6_w2", 2'b00, gc);
    drain("t6_w");
`ifdef OBI_EXT_XBAR_DEMUX_ERR_CAPTURE_EN
    check("t6_err_cnt", 32'(err_cnt_o), 32'd3);
    check("t6_err_addr", err_addr_o, 32'hF003_0000);
`endif
    hold[0] = 1'b1;
    start_req(SLOW_MEMORY_START_ADDRESS + 32'h40, 1'b0, 32'h0);
    wait_gnt("t6_r0", 2'b01, gc);
    start_req(SLOW_MEMORY_START_ADDRESS + 32'h44, 1'b0, 32'h0);
    wait_gnt("t6_r1", 2'b01, gc);
    m_req_i = 1'b0;
    check("t6_cnt_pre", 32'(dut.cnt_reg), 32'd2);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    hold[0] = 1'b0;
    exp_q.delete();
    check("t6_cnt_post", 32'(dut.cnt_reg), 32'd0);
`ifdef OBI_EXT_XBAR_DEMUX_ERR_CAPTURE_EN
    check("t6_err_cnt_post", 32'(err_cnt_o), 32'd0);
    check("t6_err_addr_post", err_addr_o, 32'd0);
`endif
    @(negedge clk_i);
    check("t6_rvalid_post", 32'(m_rvalid_o), 32'd0);
    @(posedge clk_i);
    #1;
    sc = cyc;
    start_req(SL_EXT_START_ADDRESS + 32'h8, 1'b0, (SL_EXT_START_ADDRESS + 32'h8) ^ KEY);
    wait_gnt("t6_s1", 2'b10, gc);
    check("t6_s1_gnt_cycle", 32'(gc), 32'(sc));
    drain("t6_s1");

    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
